// File: rtl/loader_pkg.sv
// Shared op codes, FSM state encoding and header field positions for program_loader.
package loader_pkg;

    typedef enum logic [1:0] {
        OP_LOAD_IMEM = 2'b00,
        OP_LOAD_DMEM = 2'b01,
        OP_RUN       = 2'b10,
        OP_HALT      = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LD_I    = 3'd1,
        ST_LD_D_LO = 3'd2,
        ST_LD_D_HI = 3'd3,
        ST_CHK     = 3'd4,
        ST_DROP    = 3'd5
    } state_e;

    localparam int HDR_OP_MSB   = 31;
    localparam int HDR_OP_LSB   = 30;
    localparam int HDR_BASE_MSB = 29;
    localparam int HDR_BASE_LSB = 16;
    localparam int HDR_CNT_MSB  = 15;
    localparam int HDR_CNT_LSB  = 0;
    localparam int BASE_W       = HDR_BASE_MSB - HDR_BASE_LSB + 1;
    localparam int CNT_W        = HDR_CNT_MSB - HDR_CNT_LSB + 1;

endpackage

// File: rtl/program_loader.sv
// Boot loader: decodes framed commands from a 32-bit stream into imem/dmem writes and core run control.
// Optional build macro LOADER_CHECKSUM_EN adds a per-frame trailer word checked against the payload sum.
module program_loader
    import loader_pkg::*;
#(
    parameter int IMEM_AW = 9,
    parameter int DMEM_AW = 10
) (
    input  logic        clk,
    input  logic        srst,
    input  logic        s_valid,
    input  logic [31:0] s_data,
    output logic        s_ready,
    output logic [63:0] addr_ext,
    output logic        wen_ext,
    output logic        ren_ext,
    output logic [31:0] wdata_ext,
    output logic [63:0] addr_ext_2,
    output logic        wen_ext_2,
    output logic        ren_ext_2,
    output logic [63:0] wdata_ext_2,
    output logic        cpu_enable,
    output logic        busy,
    output logic        error
);

    localparam logic [17:0] IMEM_DEPTH = 18'd1 << IMEM_AW;
    localparam logic [17:0] DMEM_DEPTH = 18'd1 << DMEM_AW;

`ifdef LOADER_CHECKSUM_EN
    localparam state_e ST_END   = ST_CHK;
    localparam logic   END_BUSY = 1'b1;
`else
    localparam state_e ST_END   = ST_IDLE;
    localparam logic   END_BUSY = 1'b0;
`endif

    state_e              state_r;
    logic [BASE_W-1:0]   idx_r;
    logic [CNT_W:0]      cnt_r;
    logic [31:0]         lo_r;

    op_e                 hdr_op_s;
    logic [BASE_W-1:0]   hdr_base_s;
    logic [CNT_W-1:0]    hdr_cnt_s;
    logic                hdr_is_d_s;
    logic [17:0]         hdr_sum_s;
    logic                hdr_oor_s;
    logic                cnt_last_s;

    assign hdr_op_s   = op_e'(s_data[HDR_OP_MSB:HDR_OP_LSB]);
    assign hdr_base_s = s_data[HDR_BASE_MSB:HDR_BASE_LSB];
    assign hdr_cnt_s  = s_data[HDR_CNT_MSB:HDR_CNT_LSB];
    assign hdr_is_d_s = (hdr_op_s == OP_LOAD_DMEM);
    // Range check is done on the full unwrapped sum so a frame can never alias back to low addresses
    assign hdr_sum_s  = {4'd0, hdr_base_s} + {2'd0, hdr_cnt_s};
    assign hdr_oor_s  = hdr_sum_s > (hdr_is_d_s ? DMEM_DEPTH : IMEM_DEPTH);
    assign cnt_last_s = (cnt_r == 17'd1);

    assign s_ready   = 1'b1;
    assign ren_ext   = 1'b0;
    assign ren_ext_2 = 1'b0;

`ifdef LOADER_CHECKSUM_EN
    logic [31:0] sum_r;
    logic        skip_r;
    logic        chk_bad_s;

    // Accumulate payload words of the current frame; dropped frames skip the trailer compare
    always_ff @(posedge clk) begin
        if (srst) begin
            sum_r  <= 32'd0;
            skip_r <= 1'b0;
        end else if (s_valid) begin
            case (state_r)
                ST_IDLE: begin
                    sum_r  <= 32'd0;
                    skip_r <= hdr_oor_s;
                end
                ST_LD_I, ST_LD_D_LO, ST_LD_D_HI: sum_r <= sum_r + s_data;
                default: sum_r <= sum_r;
            endcase
        end
    end

    assign chk_bad_s = !skip_r && (s_data != sum_r);
`endif

    // Frame decode, write issue and run-enable sequencing
    always_ff @(posedge clk) begin
        if (srst) begin
            state_r     <= ST_IDLE;
            idx_r       <= 14'd0;
            cnt_r       <= 17'd0;
            lo_r        <= 32'd0;
            addr_ext    <= 64'd0;
            wen_ext     <= 1'b0;
            wdata_ext   <= 32'd0;
            addr_ext_2  <= 64'd0;
            wen_ext_2   <= 1'b0;
            wdata_ext_2 <= 64'd0;
            cpu_enable  <= 1'b0;
            busy        <= 1'b0;
            error       <= 1'b0;
        end else begin
            wen_ext   <= 1'b0;
            wen_ext_2 <= 1'b0;
            if (s_valid) begin
                case (state_r)
                    ST_IDLE: begin
                        case (hdr_op_s)
                            OP_LOAD_IMEM, OP_LOAD_DMEM: begin
                                cpu_enable <= 1'b0;
                                idx_r      <= hdr_base_s;
                                error      <= error | hdr_oor_s;
                                if (hdr_cnt_s == 16'd0) begin
                                    state_r <= ST_END;
                                    busy    <= END_BUSY;
                                end else if (hdr_oor_s) begin
                                    state_r <= ST_DROP;
                                    busy    <= 1'b1;
                                    cnt_r   <= hdr_is_d_s ? {hdr_cnt_s, 1'b0} : {1'b0, hdr_cnt_s};
                                end else begin
                                    state_r <= hdr_is_d_s ? ST_LD_D_LO : ST_LD_I;
                                    busy    <= 1'b1;
                                    cnt_r   <= {1'b0, hdr_cnt_s};
                                end
                            end
                            OP_RUN:  cpu_enable <= cpu_enable | ~error;
                            OP_HALT: cpu_enable <= 1'b0;
                            default: cpu_enable <= cpu_enable;
                        endcase
                    end
                    ST_LD_I: begin
                        wen_ext   <= 1'b1;
                        addr_ext  <= {48'd0, idx_r, 2'b00};
                        wdata_ext <= s_data;
                        idx_r     <= idx_r + 14'd1;
                        cnt_r     <= cnt_r - 17'd1;
                        if (cnt_last_s) begin
                            state_r <= ST_END;
                            busy    <= END_BUSY;
                        end
                    end
                    ST_LD_D_LO: begin
                        lo_r    <= s_data;
                        state_r <= ST_LD_D_HI;
                    end
                    ST_LD_D_HI: begin
                        wen_ext_2   <= 1'b1;
                        addr_ext_2  <= {47'd0, idx_r, 3'b000};
                        wdata_ext_2 <= {s_data, lo_r};
                        idx_r       <= idx_r + 14'd1;
                        cnt_r       <= cnt_r - 17'd1;
                        if (cnt_last_s) begin
                            state_r <= ST_END;
                            busy    <= END_BUSY;
                        end else begin
                            state_r <= ST_LD_D_LO;
                        end
                    end
                    ST_DROP: begin
                        cnt_r <= cnt_r - 17'd1;
                        if (cnt_last_s) begin
                            state_r <= ST_END;
                            busy    <= END_BUSY;
                        end
                    end
`ifdef LOADER_CHECKSUM_EN
                    ST_CHK: begin
                        error   <= error | chk_bad_s;
                        state_r <= ST_IDLE;
                        busy    <= 1'b0;
                    end
`endif
                    default: begin
                        state_r <= ST_IDLE;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: frame table, hand-timed corner sequences and random frames
// compared against a frame-level reference model.
module tb_program_loader;

    localparam int IMEM_AW = 9;
    localparam int DMEM_AW = 10;

    logic        clk = 1'b0;
    logic        srst;
    logic        s_valid;
    logic [31:0] s_data;
    logic        s_ready;
    logic [63:0] addr_ext, addr_ext_2, wdata_ext_2;
    logic [31:0] wdata_ext;
    logic        wen_ext, ren_ext, wen_ext_2, ren_ext_2;
    logic        cpu_enable, busy, error;

    program_loader #(.IMEM_AW(IMEM_AW), .DMEM_AW(DMEM_AW)) dut (
        .clk(clk), .srst(srst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext), .wdata_ext(wdata_ext),
        .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
        .wdata_ext_2(wdata_ext_2), .cpu_enable(cpu_enable), .busy(busy), .error(error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int overlap_cnt = 0;

    logic [63:0] got_i_addr[$], got_d_addr[$], got_d_data[$], exp_i_addr[$], exp_d_addr[$], exp_d_data[$];
    logic [31:0] got_i_data[$], exp_i_data[$];

    bit m_err, m_cpu;

    typedef struct {
        bit         rst;
        logic [1:0] op;
        logic [13:0] base;
        logic [15:0] n;
        bit         exp_err;
        bit         exp_cpu;
        int         exp_wr;
    } vec_t;

    vec_t tbl[14];

    // Capture every write strobe seen by the memories
    always @(negedge clk) begin
        if (wen_ext) begin
            got_i_addr.push_back(addr_ext);
            got_i_data.push_back(wdata_ext);
        end
        if (wen_ext_2) begin
            got_d_addr.push_back(addr_ext_2);
            got_d_data.push_back(wdata_ext_2);
        end
        if (wen_ext && wen_ext_2) overlap_cnt++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] hdr(input logic [1:0] op, input logic [13:0] base, input logic [15:0] n);
        return {op, base, n};
    endfunction

    task automatic clear_q();
        got_i_addr.delete(); got_i_data.delete(); got_d_addr.delete(); got_d_data.delete();
        exp_i_addr.delete(); exp_i_data.delete(); exp_d_addr.delete(); exp_d_data.delete();
    endtask

    task automatic do_reset();
        s_valid = 1'b0;
        srst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        srst = 1'b0;
        m_err = 1'b0;
        m_cpu = 1'b0;
        clear_q();
    endtask

    task automatic send_word(input logic [31:0] w, input int gapmax);
        int g;
        g = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
        repeat (g) begin
            s_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        s_valid = 1'b1;
        s_data  = w;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    // Reference: interpret one whole frame with the loader's rules and send it
    task automatic run_frame(input logic [1:0] op, input logic [13:0] base, input logic [15:0] n, input int gap);
        logic [31:0] w, lo, sum;
        int words, depth;
        bit oor;
        lo = 32'd0;
        sum = 32'd0;
        send_word(hdr(op, base, n), gap);
        if (op == 2'b00 || op == 2'b01) begin
            m_cpu = 1'b0;
            depth = (op == 2'b00) ? (1 << IMEM_AW) : (1 << DMEM_AW);
            oor = (int'(base) + int'(n)) > depth;
            if (oor) m_err = 1'b1;
            words = (op == 2'b01) ? 2 * int'(n) : int'(n);
            for (int k = 0; k < words; k++) begin
                w = $urandom;
                sum += w;
                send_word(w, gap);
                if (!oor) begin
                    if (op == 2'b00) begin
                        exp_i_addr.push_back((64'(base) + 64'(k)) * 64'd4);
                        exp_i_data.push_back(w);
                    end else if (k % 2 == 0) begin
                        lo = w;
                    end else begin
                        exp_d_addr.push_back((64'(base) + 64'(k / 2)) * 64'd8);
                        exp_d_data.push_back({w, lo});
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            send_word(sum, gap);
`endif
        end else if (op == 2'b10) begin
            if (!m_err) m_cpu = 1'b1;
        end else begin
            m_cpu = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic finish_frame(input string tag);
        check({tag, "_imem_cnt"}, 64'(got_i_addr.size()), 64'(exp_i_addr.size()));
        check({tag, "_dmem_cnt"}, 64'(got_d_addr.size()), 64'(exp_d_addr.size()));
        for (int i = 0; i < exp_i_addr.size() && i < got_i_addr.size(); i++) begin
            check({tag, "_imem_addr"}, got_i_addr[i], exp_i_addr[i]);
            check({tag, "_imem_data"}, 64'(got_i_data[i]), 64'(exp_i_data[i]));
        end
        for (int i = 0; i < exp_d_addr.size() && i < got_d_addr.size(); i++) begin
            check({tag, "_dmem_addr"}, got_d_addr[i], exp_d_addr[i]);
            check({tag, "_dmem_data"}, got_d_data[i], exp_d_data[i]);
        end
        check({tag, "_error"}, 64'(error), 64'(m_err));
        check({tag, "_cpu_en"}, 64'(cpu_enable), 64'(m_cpu));
        check({tag, "_busy"}, 64'(busy), 64'd0);
        clear_q();
    endtask

    initial begin
        logic [31:0] wv[3];
        logic [1:0] rop;
        logic [13:0] rbase;

        s_valid = 1'b0;
        s_data  = 32'd0;
        srst    = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_outputs", {wen_ext, wen_ext_2, ren_ext, ren_ext_2, cpu_enable, busy, error},
              7'd0);
        check("rst_addr_data", addr_ext | addr_ext_2 | wdata_ext_2 | 64'(wdata_ext), 64'd0);
        check("s_ready", 64'(s_ready), 64'd1);
        do_reset();

        // ---- table of frames ----
        tbl[0]  = '{1'b1, 2'b10, 14'd0,     16'd0, 1'b0, 1'b1, 0};
        tbl[1]  = '{1'b0, 2'b00, 14'h10,    16'd3, 1'b0, 1'b0, 3};
        tbl[2]  = '{1'b0, 2'b01, 14'd2,     16'd1, 1'b0, 1'b0, 1};
        tbl[3]  = '{1'b0, 2'b10, 14'h1234,  16'd7, 1'b0, 1'b1, 0};
        tbl[4]  = '{1'b0, 2'b11, 14'd0,     16'd0, 1'b0, 1'b0, 0};
        tbl[5]  = '{1'b0, 2'b00, 14'h1FE,   16'd2, 1'b0, 1'b0, 2};
        tbl[6]  = '{1'b0, 2'b01, 14'h3FF,   16'd1, 1'b0, 1'b0, 1};
        tbl[7]  = '{1'b0, 2'b00, 14'd5,     16'd0, 1'b0, 1'b0, 0};
        tbl[8]  = '{1'b0, 2'b10, 14'd0,     16'd0, 1'b0, 1'b1, 0};
        tbl[9]  = '{1'b0, 2'b00, 14'h1FF,   16'd2, 1'b1, 1'b0, 0};
        tbl[10] = '{1'b0, 2'b10, 14'd0,     16'd0, 1'b1, 1'b0, 0};
        tbl[11] = '{1'b1, 2'b01, 14'h3FF,   16'd2, 1'b1, 1'b0, 0};
        tbl[12] = '{1'b1, 2'b00, 14'h3FFF,  16'd0, 1'b1, 1'b0, 0};
        tbl[13] = '{1'b1, 2'b01, 14'd0,     16'd0, 1'b0, 1'b0, 0};

        for (int t = 0; t < 14; t++) begin
            if (tbl[t].rst) do_reset();
            run_frame(tbl[t].op, tbl[t].base, tbl[t].n, t % 2 * 2);
            check($sformatf("tbl%0d_writes", t), 64'(got_i_addr.size() + got_d_addr.size()),
                  64'(tbl[t].exp_wr));
            check($sformatf("tbl%0d_err_const", t), 64'(error), 64'(tbl[t].exp_err));
            check($sformatf("tbl%0d_cpu_const", t), 64'(cpu_enable), 64'(tbl[t].exp_cpu));
            finish_frame($sformatf("tbl%0d", t));
        end

        // ---- cycle-exact imem burst: back-to-back writes, busy falls with the last ----
        do_reset();
        wv[0] = 32'hAAAA0001; wv[1] = 32'hBBBB0002; wv[2] = 32'hCCCC0003;
        s_valid = 1'b1;
        s_data  = hdr(2'b00, 14'h10, 16'd3);
        @(posedge clk);
        #1;
        s_data = wv[0];
        @(negedge clk);
        check("burst_hdr_busy", 64'(busy), 64'd1);
        check("burst_hdr_wen", 64'(wen_ext), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (i < 2) s_data = wv[i + 1];
            else s_valid = 1'b0;
            @(negedge clk);
            check("burst_wen", 64'(wen_ext), 64'd1);
            check("burst_addr", addr_ext, 64'h40 + 64'(4 * i));
            check("burst_data", 64'(wdata_ext), 64'(wv[i]));
`ifdef LOADER_CHECKSUM_EN
            check("burst_busy", 64'(busy), 64'd1);
`else
            check("burst_busy", 64'(busy), (i < 2) ? 64'd1 : 64'd0);
`endif
        end
        @(negedge clk);
        check("burst_wen_after", 64'(wen_ext), 64'd0);
        @(posedge clk);
        #1;
`ifdef LOADER_CHECKSUM_EN
        send_word(wv[0] + wv[1] + wv[2], 0);
`endif
        check("burst_error", 64'(error), 64'd0);

        // ---- run enable timing around a load header and HALT ----
        do_reset();
        send_word(hdr(2'b10, 14'd0, 16'd0), 0);
        check("run_cpu_on", 64'(cpu_enable), 64'd1);
        send_word(hdr(2'b00, 14'd0, 16'd1), 0);
        check("load_cpu_off", 64'(cpu_enable), 64'd0);
        send_word(32'd5, 0);
`ifdef LOADER_CHECKSUM_EN
        send_word(32'd5, 0);
`endif
        send_word(hdr(2'b11, 14'd0, 16'd0), 0);
        check("halt_cpu_off", 64'(cpu_enable), 64'd0);

        // ---- gapped dmem frame aborted by srst after the LO word ----
        do_reset();
        send_word(hdr(2'b00, 14'd3, 16'd1), 0);
        send_word(32'hCAFEF00D, 0);
`ifdef LOADER_CHECKSUM_EN
        send_word(32'hCAFEF00D, 0);
`endif
        send_word(hdr(2'b10, 14'd0, 16'd0), 0);
        send_word(hdr(2'b01, 14'd4, 16'd2), 0);
        @(posedge clk);
        #1;
        check("abort_busy_gap", 64'(busy), 64'd1);
        send_word(32'h11112222, 0);
        @(posedge clk);
        #1;
        check("abort_wen2_gap", 64'(wen_ext_2), 64'd0);
        srst = 1'b1;
        @(posedge clk);
        #1;
        srst = 1'b0;
        check("abort_ctrl_zero", {wen_ext, wen_ext_2, cpu_enable, busy, error}, 5'd0);
        check("abort_data_zero", addr_ext | addr_ext_2 | wdata_ext_2 | 64'(wdata_ext), 64'd0);
        check("abort_no_dmem_write", 64'(got_d_addr.size()), 64'd0);
        m_err = 1'b0;
        m_cpu = 1'b0;
        clear_q();
        send_word(hdr(2'b01, 14'd2, 16'd1), 0);
        send_word(32'h89ABCDEF, 0);
        send_word(32'h01234567, 0);
`ifdef LOADER_CHECKSUM_EN
        send_word(32'h89ABCDEF + 32'h01234567, 0);
`endif
        repeat (2) @(posedge clk);
        #1;
        check("after_abort_cnt", 64'(got_d_addr.size()), 64'd1);
        if (got_d_addr.size() > 0) begin
            check("after_abort_addr", got_d_addr[0], 64'h10);
            check("after_abort_data", got_d_data[0], 64'h01234567_89ABCDEF);
        end
        clear_q();

`ifdef LOADER_CHECKSUM_EN
        // ---- trailer checksum ----
        do_reset();
        send_word(hdr(2'b00, 14'd0, 16'd2), 0);
        send_word(32'd1, 0);
        send_word(32'd2, 0);
        send_word(32'd3, 0);
        @(posedge clk);
        #1;
        check("chk_good", 64'(error), 64'd0);
        send_word(hdr(2'b00, 14'd0, 16'd2), 0);
        send_word(32'd1, 0);
        send_word(32'd2, 0);
        send_word(32'd4, 0);
        @(posedge clk);
        #1;
        check("chk_bad", 64'(error), 64'd1);
`endif

        // ---- random frames against the model ----
        do_reset();
        for (int r = 0; r < 40; r++) begin
            if (m_err && $urandom_range(0, 2) == 0) do_reset();
            rop = 2'($urandom_range(0, 3));
            rbase = (rop == 2'b01) ? 14'($urandom_range(0, 1030)) : 14'($urandom_range(0, 515));
            run_frame(rop, rbase, 16'($urandom_range(0, 5)), int'($urandom_range(0, 2)));
            finish_frame($sformatf("rnd%0d", r));
        end

        check("wen_exclusive", 64'(overlap_cnt), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
